accel_resp_sequencer: RTL and testbench

Accelerator-side return path for CVA6 offloaded instructions. Tracks every instruction the core dispatches to the vector unit, including whether it writes a scalar destination register. Pairs rd-writing instructions with scalar results coming back from the vector backend. Returns one in-order response per instruction to the core's accelerator response port.

---
 rtl/accel_resp_sequencer_if.sv | 39 +++
 rtl/accel_resp_sequencer.sv | 120 ++++++++++++
 tb/tb_accel_resp_sequencer.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/accel_resp_sequencer_if.sv
// rtl/accel_resp_sequencer_if.sv - request/result/response bundle for accel_resp_sequencer
// Signal suffixes are from the sequencer's point of view (slave modport).
interface accel_resp_sequencer_if #(
    parameter int NrEntries = 4,
    parameter int TransIdW  = 3,
    parameter int XLEN      = 64
);
    logic                           req_valid_i;
    logic                           req_ready_o;
    logic [TransIdW-1:0]            req_trans_id_i;
    logic                           req_is_rd_i;
    logic [4:0]                     req_rd_i;
    logic                           res_valid_i;
    logic                           res_ready_o;
    logic [XLEN-1:0]                res_data_i;
    logic                           res_error_i;
    logic                           resp_valid_o;
    logic                           resp_ready_i;
    logic [TransIdW-1:0]            resp_trans_id_o;
    logic [XLEN-1:0]                resp_data_o;
    logic                           resp_we_o;
    logic [4:0]                     resp_rd_o;
    logic                           resp_error_o;
    logic [$clog2(NrEntries+1)-1:0] outstanding_o;

    modport master (
        output req_valid_i, req_trans_id_i, req_is_rd_i, req_rd_i,
        output res_valid_i, res_data_i, res_error_i, resp_ready_i,
        input  req_ready_o, res_ready_o, resp_valid_o, resp_trans_id_o,
        input  resp_data_o, resp_we_o, resp_rd_o, resp_error_o, outstanding_o
    );

    modport slave (
        input  req_valid_i, req_trans_id_i, req_is_rd_i, req_rd_i,
        input  res_valid_i, res_data_i, res_error_i, resp_ready_i,
        output req_ready_o, res_ready_o, resp_valid_o, resp_trans_id_o,
        output resp_data_o, resp_we_o, resp_rd_o, resp_error_o, outstanding_o
    );
endinterface

// File: rtl/accel_resp_sequencer.sv
// rtl/accel_resp_sequencer.sv - in-order accelerator response sequencer
// Optional feature: ACCEL_RESP_ERROR_EN stores result errors and suppresses rd writes on error.
module accel_resp_sequencer #(
    parameter int NrEntries = 4,
    parameter int TransIdW  = 3,
    parameter int XLEN      = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    accel_resp_sequencer_if.slave bus
);
    localparam int PtrW = (NrEntries > 1) ? $clog2(NrEntries) : 1;
    localparam int CntW = $clog2(NrEntries + 1);
    localparam logic [CntW-1:0] Full = CntW'(NrEntries);

    logic [TransIdW-1:0]  id_mem_q   [NrEntries];
    logic [4:0]           rd_mem_q   [NrEntries];
    logic [XLEN-1:0]      data_mem_q [NrEntries];
    logic [NrEntries-1:0] is_rd_mem_q;
`ifdef ACCEL_RESP_ERROR_EN
    logic [NrEntries-1:0] err_mem_q;
`endif

    logic [PtrW-1:0] iwptr_q, iwptr_d, irptr_q, irptr_d;
    logic [PtrW-1:0] rwptr_q, rwptr_d, rrptr_q, rrptr_d;
    logic [CntW-1:0] icnt_q, icnt_d, rcnt_q, rcnt_d, pend_q, pend_d;

    logic clr, req_push, res_push, resp_fire, res_pop;
    logic head_valid, head_is_rd, res_avail, head_err;

    assign clr        = rst_i | flush_i;
    assign head_valid = (icnt_q != '0);
    assign head_is_rd = is_rd_mem_q[irptr_q];
    assign res_avail  = (rcnt_q != '0);

    // No bypass when full: readiness depends only on registered occupancy.
    assign bus.req_ready_o   = (icnt_q != Full);
    assign bus.res_ready_o   = (pend_q != '0) && (rcnt_q != Full);
    assign bus.outstanding_o = icnt_q;

    assign req_push  = bus.req_valid_i & bus.req_ready_o & ~clr;
    assign res_push  = bus.res_valid_i & bus.res_ready_o & ~clr;
    assign resp_fire = bus.resp_valid_o & bus.resp_ready_i & ~clr;
    assign res_pop   = resp_fire & head_is_rd;

`ifdef ACCEL_RESP_ERROR_EN
    assign head_err = err_mem_q[rrptr_q];
`else
    logic unused_res_error;
    assign unused_res_error = bus.res_error_i;
    assign head_err         = 1'b0;
`endif

    always_comb begin
        iwptr_d = iwptr_q + PtrW'(req_push);
        irptr_d = irptr_q + PtrW'(resp_fire);
        rwptr_d = rwptr_q + PtrW'(res_push);
        rrptr_d = rrptr_q + PtrW'(res_pop);
        icnt_d  = icnt_q + CntW'(req_push) - CntW'(resp_fire);
        rcnt_d  = rcnt_q + CntW'(res_push) - CntW'(res_pop);
        pend_d  = pend_q + CntW'(req_push & bus.req_is_rd_i) - CntW'(res_push);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            iwptr_q <= '0;
            irptr_q <= '0;
            rwptr_q <= '0;
            rrptr_q <= '0;
            icnt_q  <= '0;
            rcnt_q  <= '0;
            pend_q  <= '0;
        end else begin
            iwptr_q <= iwptr_d;
            irptr_q <= irptr_d;
            rwptr_q <= rwptr_d;
            rrptr_q <= rrptr_d;
            icnt_q  <= icnt_d;
            rcnt_q  <= rcnt_d;
            pend_q  <= pend_d;
        end
    end

    // Payload storage is never cleared; the counters decide what is live.
    always_ff @(posedge clk_i) begin
        if (req_push) begin
            id_mem_q[iwptr_q]    <= bus.req_trans_id_i;
            rd_mem_q[iwptr_q]    <= bus.req_rd_i;
            is_rd_mem_q[iwptr_q] <= bus.req_is_rd_i;
        end
        if (res_push) begin
            data_mem_q[rwptr_q] <= bus.res_data_i;
`ifdef ACCEL_RESP_ERROR_EN
            err_mem_q[rwptr_q]  <= bus.res_error_i;
`endif
        end
    end

    always_comb begin
        bus.resp_valid_o    = 1'b0;
        bus.resp_trans_id_o = '0;
        bus.resp_rd_o       = '0;
        bus.resp_data_o     = '0;
        bus.resp_we_o       = 1'b0;
        bus.resp_error_o    = 1'b0;
        if (head_valid) begin
            bus.resp_trans_id_o = id_mem_q[irptr_q];
            bus.resp_rd_o       = rd_mem_q[irptr_q];
            if (!head_is_rd) begin
                bus.resp_valid_o = 1'b1;
            end else if (res_avail) begin
                bus.resp_valid_o = 1'b1;
                bus.resp_data_o  = data_mem_q[rrptr_q];
                bus.resp_error_o = head_err;
                bus.resp_we_o    = ~head_err;
            end
        end
    end
endmodule

// File: tb/tb_accel_resp_sequencer.sv
// tb/tb_accel_resp_sequencer.sv - scoreboard bench for accel_resp_sequencer
module tb_accel_resp_sequencer;
    localparam int NE = 4;

    typedef struct {
        logic [2:0] id;
        bit         is_rd;
        logic [4:0] rd;
    } ent_t;

    typedef struct {
        logic [63:0] data;
        bit          err;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    int   total = 0;
    int   bad = 0;

    ent_t m_iq[$];
    res_t m_rq[$];
    int   m_pend = 0;

    accel_resp_sequencer_if #(.NrEntries(NE), .TransIdW(3), .XLEN(64)) bus ();

    accel_resp_sequencer #(.NrEntries(NE), .TransIdW(3), .XLEN(64)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .flush_i (flush),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_req(input bit v, input logic [2:0] id, input bit is_rd, input logic [4:0] rd);
        bus.req_valid_i    = v;
        bus.req_trans_id_i = id;
        bus.req_is_rd_i    = is_rd;
        bus.req_rd_i       = rd;
    endtask

    task automatic drive_res(input bit v, input logic [63:0] data, input bit err);
        bus.res_valid_i = v;
        bus.res_data_i  = data;
        bus.res_error_i = err;
    endtask

    // One clock: check DUT against model, advance model on handshakes, step the edge.
    task automatic tick();
        bit   rq_ok, rs_ok, rv, clear, err;
        ent_t e;
        res_t r;
        #2;
        rq_ok = (m_iq.size() != NE);
        rs_ok = (m_pend != 0) && (m_rq.size() != NE);
        rv    = (m_iq.size() != 0) && (!m_iq[0].is_rd || m_rq.size() != 0);
        chk("req_ready", bus.req_ready_o, rq_ok);
        chk("res_ready", bus.res_ready_o, rs_ok);
        chk("resp_valid", bus.resp_valid_o, rv);
        chk("outstanding", bus.outstanding_o, m_iq.size());
        if (rv) begin
            chk("resp_id", bus.resp_trans_id_o, m_iq[0].id);
            chk("resp_rd", bus.resp_rd_o, m_iq[0].rd);
            if (m_iq[0].is_rd) begin
                chk("resp_data", bus.resp_data_o, m_rq[0].data);
                chk("resp_err", bus.resp_error_o, m_rq[0].err);
                chk("resp_we", bus.resp_we_o, !m_rq[0].err);
            end else begin
                chk("resp_data", bus.resp_data_o, 64'h0);
                chk("resp_err", bus.resp_error_o, 1'b0);
                chk("resp_we", bus.resp_we_o, 1'b0);
            end
        end
        clear = rst || flush;
        if (!clear) begin
            if (rv && bus.resp_ready_i) begin
                if (m_iq[0].is_rd) void'(m_rq.pop_front());
                void'(m_iq.pop_front());
            end
            if (bus.req_valid_i && rq_ok) begin
                e.id = bus.req_trans_id_i;
                e.is_rd = bus.req_is_rd_i;
                e.rd = bus.req_rd_i;
                m_iq.push_back(e);
                if (e.is_rd) m_pend++;
            end
            if (bus.res_valid_i && rs_ok) begin
`ifdef ACCEL_RESP_ERROR_EN
                err = bus.res_error_i;
`else
                err = 1'b0;
`endif
                r.data = bus.res_data_i;
                r.err = err;
                m_rq.push_back(r);
                m_pend--;
            end
        end
        @(posedge clk);
        #1;
        if (clear) begin
            m_iq.delete();
            m_rq.delete();
            m_pend = 0;
        end
    endtask

    initial begin
        drive_req(0, 3'd0, 0, 5'd0);
        drive_res(0, 64'h0, 0);
        bus.resp_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_valid", bus.resp_valid_o, 1'b0);
        chk("rst_req_ready", bus.req_ready_o, 1'b1);
        chk("rst_res_ready", bus.res_ready_o, 1'b0);
        chk("rst_outstanding", bus.outstanding_o, 0);
        chk("rst_id", bus.resp_trans_id_o, 0);
        chk("rst_data", bus.resp_data_o, 0);
        chk("rst_we", bus.resp_we_o, 0);
        chk("rst_rd", bus.resp_rd_o, 0);
        chk("rst_err", bus.resp_error_o, 0);

        // single non-rd instruction
        drive_req(1, 3'd5, 0, 5'd1);
        tick();
        drive_req(0, 3'd0, 0, 5'd0);
        chk("t1_valid", bus.resp_valid_o, 1'b1);
        chk("t1_id", bus.resp_trans_id_o, 5);
        chk("t1_we", bus.resp_we_o, 0);
        bus.resp_ready_i = 1'b1;
        tick();
        bus.resp_ready_i = 1'b0;
        chk("t1_outstanding", bus.outstanding_o, 0);

        // rd instruction waits for its result
        drive_req(1, 3'd2, 1, 5'd7);
        tick();
        drive_req(0, 3'd0, 0, 5'd0);
        for (int i = 0; i < 5; i++) begin
            chk("t2_wait_valid", bus.resp_valid_o, 1'b0);
            tick();
        end
        drive_res(1, 64'hDEAD, 0);
        tick();
        drive_res(0, 64'h0, 0);
        chk("t2_valid", bus.resp_valid_o, 1'b1);
        chk("t2_data", bus.resp_data_o, 64'hDEAD);
        chk("t2_we", bus.resp_we_o, 1'b1);
        chk("t2_rd", bus.resp_rd_o, 7);
        bus.resp_ready_i = 1'b1;
        tick();

        // ID1, rd ID2 (delayed result), ID3
        drive_req(1, 3'd1, 0, 5'd0);
        tick();
        drive_req(1, 3'd2, 1, 5'd4);
        tick();
        drive_req(1, 3'd3, 0, 5'd0);
        tick();
        drive_req(0, 3'd0, 0, 5'd0);
        repeat (3) tick();
        chk("t3_stall_valid", bus.resp_valid_o, 1'b0);
        chk("t3_stall_out", bus.outstanding_o, 2);
        drive_res(1, 64'h1234, 0);
        tick();
        drive_res(0, 64'h0, 0);
        repeat (2) tick();
        chk("t3_drained", bus.outstanding_o, 0);

        // fill, no bypass while full, then wrap with simultaneous push/pop
        bus.resp_ready_i = 1'b0;
        for (int i = 0; i < NE; i++) begin
            drive_req(1, 3'(i), 0, 5'(i));
            tick();
        end
        drive_req(0, 3'd0, 0, 5'd0);
        chk("t4_full_ready", bus.req_ready_o, 1'b0);
        chk("t4_full_out", bus.outstanding_o, NE);
        drive_req(1, 3'd4, 0, 5'd4);
        bus.resp_ready_i = 1'b1;
        tick();
        chk("t4_nobypass_out", bus.outstanding_o, NE - 1);
        for (int i = 0; i < 6; i++) begin
            drive_req(1, 3'(4 + i), 0, 5'(i));
            tick();
            chk("t4_pair_out", bus.outstanding_o, NE - 1);
        end
        drive_req(0, 3'd0, 0, 5'd0);
        repeat (4) tick();

        // held response stays valid, then simultaneous enqueue and pop
        bus.resp_ready_i = 1'b0;
        drive_req(1, 3'd3, 1, 5'd12);
        tick();
        drive_req(0, 3'd0, 0, 5'd0);
        drive_res(1, 64'h55AA, 0);
        tick();
        drive_res(0, 64'h0, 0);
        repeat (3) tick();
        chk("t5_held_data", bus.resp_data_o, 64'h55AA);
        drive_req(1, 3'd6, 0, 5'd2);
        bus.resp_ready_i = 1'b1;
        tick();
        drive_req(0, 3'd0, 0, 5'd0);
        chk("t5_simul_out", bus.outstanding_o, 1);
        tick();

        // flush with 3 entries and one pending result
        bus.resp_ready_i = 1'b0;
        drive_req(1, 3'd6, 1, 5'd3);
        tick();
        drive_req(1, 3'd0, 0, 5'd0);
        tick();
        drive_req(1, 3'd1, 0, 5'd0);
        tick();
        drive_req(0, 3'd0, 0, 5'd0);
        chk("t6_pre_out", bus.outstanding_o, 3);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t6_out", bus.outstanding_o, 0);
        chk("t6_valid", bus.resp_valid_o, 1'b0);
        chk("t6_res_ready", bus.res_ready_o, 1'b0);
        chk("t6_data", bus.resp_data_o, 0);

`ifdef ACCEL_RESP_ERROR_EN
        drive_req(1, 3'd4, 1, 5'd9);
        tick();
        drive_req(0, 3'd0, 0, 5'd0);
        drive_res(1, 64'hBAD, 1);
        tick();
        drive_res(0, 64'h0, 0);
        chk("t7_err", bus.resp_error_o, 1'b1);
        chk("t7_we", bus.resp_we_o, 1'b0);
        bus.resp_ready_i = 1'b1;
        tick();
`endif

        // random traffic against the model
        for (int i = 0; i < 300; i++) begin
            drive_req(($urandom_range(0, 2) != 0), 3'($urandom), 1'($urandom), 5'($urandom));
            drive_res(($urandom_range(0, 1) != 0), {$urandom, $urandom}, 1'($urandom));
            bus.resp_ready_i = ($urandom_range(0, 3) != 0);
            tick();
        end
        drive_req(0, 3'd0, 0, 5'd0);
        drive_res(0, 64'h0, 0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
